// File: rtl/rect_fill_if.sv
// Command bus from the game FSM plus the pixel plot bus toward the VGA adapter.
// The engine connects through the slave modport and its driver through the master modport.
interface rect_fill_if #(
  parameter int unsigned X_W     = 9,
  parameter int unsigned Y_W     = 8,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned DIM_W   = 6
);
  logic               start;
  logic               mode;
  logic [X_W-1:0]     x0;
  logic [Y_W-1:0]     y0;
  logic [DIM_W-1:0]   rect_w;
  logic [DIM_W-1:0]   rect_h;
  logic [COLOR_W-1:0] color;
  logic               abort;
  logic               busy;
  logic               done;
  logic [X_W-1:0]     vga_x;
  logic [Y_W-1:0]     vga_y;
  logic [COLOR_W-1:0] vga_colour;
  logic               vga_plot;

  modport master (
    output start, mode, x0, y0, rect_w, rect_h, color, abort,
    input  busy, done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, mode, x0, y0, rect_w, rect_h, color, abort,
    output busy, done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/rect_fill_drawer.sv
// Rectangle-fill / screen-clear engine: one pixel slot per clock, clipped to the screen,
// with abort and a start/busy/done handshake.
module rect_fill_drawer #(
  parameter int unsigned X_W      = 9,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned DIM_W    = 6,
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240
) (
  input logic        clock,
  input logic        reset,
  rect_fill_if.slave bus
);
  localparam int unsigned CX_W = (X_W > DIM_W) ? X_W : DIM_W;
  localparam int unsigned CY_W = (Y_W > DIM_W) ? Y_W : DIM_W;
  localparam int unsigned SX_W = X_W + 1;
  localparam int unsigned SY_W = Y_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t             r_state, w_state;
  logic [X_W-1:0]     r_x0, w_x0;
  logic [Y_W-1:0]     r_y0, w_y0;
  logic [CX_W-1:0]    r_w, w_w, r_cx, w_cx;
  logic [CY_W-1:0]    r_h, w_h, r_cy, w_cy;
  logic [COLOR_W-1:0] r_color, w_color;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_plot, w_plot;
  logic [X_W-1:0]     r_vga_x, w_vga_x;
  logic [Y_W-1:0]     r_vga_y, w_vga_y;
  logic [COLOR_W-1:0] r_vga_colour, w_vga_colour;
  logic               w_emit;
  logic [SX_W-1:0]    w_sx;
  logic [SY_W-1:0]    w_sy;

  // State, latched command, counters and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_x0         <= '0;
      r_y0         <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_color      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_plot       <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
    end else begin
      r_state      <= w_state;
      r_x0         <= w_x0;
      r_y0         <= w_y0;
      r_w          <= w_w;
      r_h          <= w_h;
      r_cx         <= w_cx;
      r_cy         <= w_cy;
      r_color      <= w_color;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_plot       <= w_plot;
      r_vga_x      <= w_vga_x;
      r_vga_y      <= w_vga_y;
      r_vga_colour <= w_vga_colour;
    end
  end

  // Next state; the pixel emitted next cycle is computed from the next-cycle counters
  always_comb begin
    w_state = r_state;
    w_x0    = r_x0;
    w_y0    = r_y0;
    w_w     = r_w;
    w_h     = r_h;
    w_cx    = r_cx;
    w_cy    = r_cy;
    w_color = r_color;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_emit  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_x0    = bus.mode ? '0 : bus.x0;
          w_y0    = bus.mode ? '0 : bus.y0;
          w_w     = bus.mode ? CX_W'(SCREEN_W) : CX_W'(bus.rect_w);
          w_h     = bus.mode ? CY_W'(SCREEN_H) : CY_W'(bus.rect_h);
          w_color = bus.color;
          w_cx    = '0;
          w_cy    = '0;
          if (w_w == '0 || w_h == '0) begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end else begin
            w_state = S_DRAW;
            w_busy  = 1'b1;
            w_emit  = 1'b1;
          end
        end
      end
      S_DRAW: begin
        if (bus.abort || (r_cx == r_w - CX_W'(1) && r_cy == r_h - CY_W'(1))) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end else begin
          w_busy = 1'b1;
          w_emit = 1'b1;
          if (r_cx == r_w - CX_W'(1)) begin
            w_cx = '0;
            w_cy = r_cy + CY_W'(1);
          end else begin
            w_cx = r_cx + CX_W'(1);
          end
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    // Widened sums so off-screen pixels are detected instead of wrapping
    w_sx         = SX_W'(w_x0) + SX_W'(w_cx);
    w_sy         = SY_W'(w_y0) + SY_W'(w_cy);
    w_plot       = w_emit && (w_sx < SX_W'(SCREEN_W)) && (w_sy < SY_W'(SCREEN_H));
    w_vga_x      = w_emit ? w_sx[X_W-1:0] : '0;
    w_vga_y      = w_emit ? w_sy[Y_W-1:0] : '0;
    w_vga_colour = w_emit ? w_color : '0;
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.vga_plot   = r_plot;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;
endmodule

// File: tb/tb_rect_fill_drawer.sv
// Bench for rect_fill_drawer: per-cycle expectations come from a row-major pixel model
// of each command; directed cases pin latencies and plot counts to literal values.
module tb_rect_fill_drawer;
  localparam int unsigned X_W = 9;
  localparam int unsigned Y_W = 8;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned DIM_W = 6;
  localparam int SW = 320;
  localparam int SH = 240;

  logic clock;
  logic reset;

  rect_fill_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .DIM_W(DIM_W)) bus ();

  rect_fill_drawer #(
    .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .DIM_W(DIM_W),
    .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       busy;
    logic       done;
    logic       plot;
    bit         chk;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] col;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_x, first_y, last_x, last_y;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Pixel i of a W-wide rectangle anchored at (X0,Y0), row-major
  function automatic void model_pix(input int i, input int w, input int x0, input int y0,
                                    output int ax, output int ay);
    ax = x0 + i % w;
    ay = y0 + i / w;
  endfunction

  function automatic exp_t zero_item(input bit chk);
    exp_t e;
    e.busy = 1'b0; e.done = 1'b0; e.plot = 1'b0; e.chk = chk;
    e.x = '0; e.y = '0; e.col = '0;
    return e;
  endfunction

  // Per-cycle comparison against the expectation queue; an empty queue means idle
  always @(negedge clock) begin : cmp
    exp_t e;
    cyc++;
    if (q.size() > 0) e = q.pop_front();
    else e = zero_item(1'b0);
    checks++;
    if (bus.busy !== e.busy || bus.done !== e.done || bus.vga_plot !== e.plot ||
        (e.chk && (bus.vga_x !== e.x || bus.vga_y !== e.y || bus.vga_colour !== e.col))) begin
      errors++;
      $display("FAIL cycle %0d outputs: got busy=%b done=%b plot=%b x=%0d y=%0d c=%0d, required busy=%b done=%b plot=%b x=%0d y=%0d c=%0d",
               cyc, bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour,
               e.busy, e.done, e.plot, e.x, e.y, e.col);
    end
    if (bus.vga_plot === 1'b1) begin
      if (plot_cnt == 0) begin
        first_x = int'(bus.vga_x);
        first_y = int'(bus.vga_y);
      end
      last_x = int'(bus.vga_x);
      last_y = int'(bus.vga_y);
      plot_cnt++;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Issue one command; abort/restart/reset are applied during the t-th slot after start (-1 = never)
  task automatic run_cmd(input bit md, input int x0, input int y0, input int w, input int h,
                         input int c, input int abort_at, input int restart_at,
                         input int reset_at, output int lat);
    int wd, ht, ax0, ay0, n, e_cnt, ax, ay, t, start_cyc, nplots;
    exp_t e;
    bit fin;
    wd  = md ? SW : w;
    ht  = md ? SH : h;
    ax0 = md ? 0 : x0;
    ay0 = md ? 0 : y0;
    n   = wd * ht;
    e_cnt = (abort_at >= 0 && abort_at < n) ? abort_at + 1 : n;
    nplots = 0;
    @(negedge clock);
    #1;
    for (int i = 0; i < e_cnt; i++) begin
      model_pix(i, wd, ax0, ay0, ax, ay);
      e.busy = 1'b1; e.done = 1'b0; e.chk = 1'b1;
      e.plot = (ax < SW) && (ay < SH);
      e.x = 9'(ax); e.y = 8'(ay); e.col = 3'(c);
      if (e.plot) nplots++;
      q.push_back(e);
    end
    e = zero_item(1'b0);
    e.done = 1'b1;
    q.push_back(e);
    plot_cnt  = 0;
    start_cyc = cyc;
    bus.start  = 1'b1;
    bus.mode   = md;
    bus.x0     = 9'(x0);
    bus.y0     = 8'(y0);
    bus.rect_w = 6'(w);
    bus.rect_h = 6'(h);
    bus.color  = 3'(c);
    bus.abort  = ($urandom_range(0, 3) == 0);
    t = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clock);
      #1;
      if (t == 0) begin
        bus.start  = 1'b0;
        bus.mode   = 1'($urandom);
        bus.x0     = 9'($urandom);
        bus.y0     = 8'($urandom);
        bus.rect_w = 6'($urandom);
        bus.rect_h = 6'($urandom);
        bus.color  = 3'($urandom);
        bus.abort  = 1'b0;
      end
      if (t == restart_at) bus.start = 1'b1;
      else if (t == restart_at + 1) bus.start = 1'b0;
      if (t == abort_at) bus.abort = 1'b1;
      else if (t == abort_at + 1) bus.abort = 1'b0;
      if (t == reset_at) begin
        reset = 1'b1;
        q.delete();
        q.push_back(zero_item(1'b1));
      end else if (t == reset_at + 1) begin
        reset = 1'b0;
      end
      if (q.size() == 0 && (reset_at < 0 || t > reset_at)) begin
        fin = 1'b1;
      end else if (t > e_cnt + 8) begin
        check("timeout_waiting_for_done", t, e_cnt);
        q.delete();
        fin = 1'b1;
      end
      t++;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    reset = 1'b0;
    lat = (done_cyc > start_cyc) ? done_cyc - start_cyc : -1;
    if (reset_at < 0) begin
      check("done_latency", lat, e_cnt + 1);
      check("plot_count", plot_cnt, nplots);
    end
  endtask

  initial begin
    int lat, ax, ay, cnt, d0, w, h;
    reset = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.x0 = '0; bus.y0 = '0;
    bus.rect_w = '0; bus.rect_h = '0; bus.color = '0; bus.abort = 1'b0;
    q.push_back(zero_item(1'b1));
    q.push_back(zero_item(1'b1));
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;

    // Literal pins on the model itself
    model_pix(15, 4, 10, 20, ax, ay);
    check("model_4x4_last_x", ax, 13);
    check("model_4x4_last_y", ay, 23);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      model_pix(i, 4, 318, 238, ax, ay);
      if (ax < SW && ay < SH) cnt++;
    end
    check("model_clip_plots", cnt, 4);

    run_cmd(1'b0, 10, 20, 4, 4, 5, -1, -1, -1, lat);
    check("fill4_plots", plot_cnt, 16);
    check("fill4_lat", lat, 17);
    check("fill4_first_x", first_x, 10);
    check("fill4_first_y", first_y, 20);
    check("fill4_last_x", last_x, 13);
    check("fill4_last_y", last_y, 23);

    run_cmd(1'b0, 318, 238, 4, 4, 2, -1, -1, -1, lat);
    check("clip_plots", plot_cnt, 4);
    check("clip_lat", lat, 17);
    check("clip_last_x", last_x, 319);
    check("clip_last_y", last_y, 239);

    run_cmd(1'b0, 7, 9, 0, 5, 3, -1, -1, -1, lat);
    check("zero_w_lat", lat, 1);
    run_cmd(1'b0, 7, 9, 5, 0, 3, -1, -1, -1, lat);
    check("zero_h_lat", lat, 1);

    run_cmd(1'b0, 100, 50, 8, 8, 6, -1, 20, -1, lat);
    check("restart_ignored_plots", plot_cnt, 64);
    check("restart_ignored_lat", lat, 65);
    run_cmd(1'b0, 100, 50, 8, 8, 6, 10, 3, -1, lat);
    check("abort_plots", plot_cnt, 11);
    check("abort_lat", lat, 12);
    run_cmd(1'b0, 30, 40, 3, 3, 1, 7, -1, -1, lat);
    check("abort_last_edge_plots", plot_cnt, 8);
    check("abort_last_edge_lat", lat, 9);

    d0 = done_cnt;
    run_cmd(1'b0, 5, 5, 63, 63, 4, -1, -1, 40, lat);
    check("reset_no_done", done_cnt, d0);
    run_cmd(1'b0, 1, 2, 2, 3, 7, -1, -1, -1, lat);
    check("after_reset_plots", plot_cnt, 6);
    check("after_reset_lat", lat, 7);

    run_cmd(1'b1, 123, 45, 17, 9, 0, -1, -1, -1, lat);
    check("clear_plots", plot_cnt, 76800);
    check("clear_lat", lat, 76801);
    check("clear_first_x", first_x, 0);
    check("clear_first_y", first_y, 0);
    check("clear_last_x", last_x, 319);
    check("clear_last_y", last_y, 239);

    for (int k = 0; k < 24; k++) begin
      w = int'($urandom_range(0, 20));
      h = int'($urandom_range(0, 20));
      run_cmd(1'b0, int'($urandom_range(0, 511)), int'($urandom_range(0, 255)), w, h,
              int'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w * h + 1)) : -1,
              ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 10)) : -1,
              -1, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
